csr_trap_ctrl: RTL and testbench

- Machine-mode trap sequencer that sits between the pipeline and the CSR file.
- On a synchronous exception, an enabled interrupt, or an MRET, it does four things in order: flushes the pipeline, writes the trap CSRs through the CSR file's write port one register per cycle, updates mstatus, then issues a single-cycle PC redirect.
- It owns no architectural state except its latched trap context.

---
 rtl/riscv_csr_pkg.sv | 35 +++
 rtl/trap_irq_select.sv | 28 ++
 rtl/csr_trap_ctrl.sv | 150 +++++++++++++++
 tb/tb_csr_trap_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, mstatus fields, interrupt
// cause codes and the trap sequencer state encoding.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Bit positions inside irq_pending / mie_q
  localparam int IRQ_MSI_BIT = 0;
  localparam int IRQ_MTI_BIT = 1;
  localparam int IRQ_MEI_BIT = 2;

  localparam logic [4:0] IRQ_CAUSE_MSI = 5'd3;
  localparam logic [4:0] IRQ_CAUSE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CAUSE_MEI = 5'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_WR_MEPC,
    ST_WR_MCAUSE,
    ST_WR_MTVAL,
    ST_WR_MSTATUS,
    ST_REDIRECT
  } trap_state_e;

endpackage

// File: rtl/trap_irq_select.sv
// Picks the highest-priority enabled machine interrupt: MEI, then MSI, then MTI.
module trap_irq_select
  import riscv_csr_pkg::*;
(
  input  logic [2:0] irq_active,
  input  logic       mie,
  output logic       irq_take,
  output logic [4:0] irq_cause
);

  always_comb begin
    irq_take  = 1'b0;
    irq_cause = '0;
    if (mie) begin
      if (irq_active[IRQ_MEI_BIT]) begin
        irq_take  = 1'b1;
        irq_cause = IRQ_CAUSE_MEI;
      end else if (irq_active[IRQ_MSI_BIT]) begin
        irq_take  = 1'b1;
        irq_cause = IRQ_CAUSE_MSI;
      end else if (irq_active[IRQ_MTI_BIT]) begin
        irq_take  = 1'b1;
        irq_cause = IRQ_CAUSE_MTI;
      end
    end
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Machine-mode trap/MRET sequencer: flush, write trap CSRs one per cycle,
// update mstatus, then issue a single-cycle PC redirect.
module csr_trap_ctrl
  import riscv_csr_pkg::*;
#(
  parameter int CSR_ADDR_W = 12,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_cause,
  input  logic [XLEN-1:0]       exc_pc,
  input  logic [XLEN-1:0]       exc_tval,
  input  logic                  mret_valid,
  input  logic [2:0]            irq_pending,
  input  logic [XLEN-1:0]       irq_pc,
  input  logic [2:0]            mie_q,
  input  logic [XLEN-1:0]       mstatus_q,
  input  logic [XLEN-1:0]       mtvec_q,
  input  logic [XLEN-1:0]       mepc_q,
  output logic                  flush_req,
  input  logic                  flush_ack,
  output logic                  busy,
  output logic                  csr_trap_we,
  output logic [CSR_ADDR_W-1:0] csr_trap_addr,
  output logic [XLEN-1:0]       csr_trap_wdata,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc
);

  trap_state_e     state_q, state_d;
  logic            is_irq_q, is_mret_q;
  logic [4:0]      cause_q;
  logic [XLEN-3:0] pc_q;
  logic [XLEN-1:0] tval_q;

  logic            irq_take;
  logic [4:0]      irq_cause;
  logic            accept;
  logic [XLEN-1:0] tvec_base;
  logic            unused_ok;

  function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] m);
    logic [XLEN-1:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  trap_irq_select u_irq_select (
    .irq_active (irq_pending & mie_q),
    .mie        (mstatus_q[MSTATUS_MIE]),
    .irq_take   (irq_take),
    .irq_cause  (irq_cause)
  );

  assign accept    = (state_q == ST_IDLE) && (exc_valid || irq_take || mret_valid);
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign unused_ok = ^{exc_pc[1:0], irq_pc[1:0], mepc_q[1:0]};

  // Context is captured only at acceptance; exception beats interrupt beats MRET
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_irq_q  <= !exc_valid && irq_take;
        is_mret_q <= !exc_valid && !irq_take;
        cause_q   <= exc_valid ? exc_cause : (irq_take ? irq_cause : 5'd0);
        pc_q      <= exc_valid ? exc_pc[XLEN-1:2] : (irq_take ? irq_pc[XLEN-1:2] : '0);
        tval_q    <= exc_valid ? exc_tval : '0;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    flush_req      = 1'b0;
    busy           = (state_q != ST_IDLE);
    csr_trap_we    = 1'b0;
    csr_trap_addr  = '0;
    csr_trap_wdata = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) state_d = is_mret_q ? ST_WR_MSTATUS : ST_WR_MEPC;
      end
      ST_WR_MEPC: begin
        csr_trap_we    = 1'b1;
        csr_trap_addr  = CSR_ADDR_W'(CSR_MEPC);
        csr_trap_wdata = {pc_q, 2'b00};
        state_d        = ST_WR_MCAUSE;
      end
      ST_WR_MCAUSE: begin
        csr_trap_we    = 1'b1;
        csr_trap_addr  = CSR_ADDR_W'(CSR_MCAUSE);
        csr_trap_wdata = {is_irq_q, {(XLEN-6){1'b0}}, cause_q};
        state_d        = ST_WR_MTVAL;
      end
      ST_WR_MTVAL: begin
        csr_trap_we    = 1'b1;
        csr_trap_addr  = CSR_ADDR_W'(CSR_MTVAL);
        csr_trap_wdata = tval_q;
        state_d        = ST_WR_MSTATUS;
      end
      ST_WR_MSTATUS: begin
        csr_trap_we    = 1'b1;
        csr_trap_addr  = CSR_ADDR_W'(CSR_MSTATUS);
        csr_trap_wdata = is_mret_q ? mstatus_on_mret(mstatus_q) : mstatus_on_trap(mstatus_q);
        state_d        = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        // Vectored mode only offsets interrupts; modes 2/3 behave as direct
        if (is_mret_q)
          redirect_pc = {mepc_q[XLEN-1:2], 2'b00};
        else if (is_irq_q && mtvec_q[1:0] == 2'b01)
          redirect_pc = tvec_base + {{(XLEN-7){1'b0}}, cause_q, 2'b00};
        else
          redirect_pc = tvec_base;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Directed bench for csr_trap_ctrl: per-cycle vector table plus hand-written
// sequences for interrupts, priority, masking, delayed flush and reset abort.
module tb_csr_trap_ctrl;

  logic        clk;
  logic        reset_n;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] exc_tval;
  logic        mret_valid;
  logic [2:0]  irq_pending;
  logic [31:0] irq_pc;
  logic [2:0]  mie_q;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic        flush_req;
  logic        flush_ack;
  logic        busy;
  logic        csr_trap_we;
  logic [11:0] csr_trap_addr;
  logic [31:0] csr_trap_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  csr_trap_ctrl #(.CSR_ADDR_W(12), .XLEN(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret_valid     (mret_valid),
    .irq_pending    (irq_pending),
    .irq_pc         (irq_pc),
    .mie_q          (mie_q),
    .mstatus_q      (mstatus_q),
    .mtvec_q        (mtvec_q),
    .mepc_q         (mepc_q),
    .flush_req      (flush_req),
    .flush_ack      (flush_ack),
    .busy           (busy),
    .csr_trap_we    (csr_trap_we),
    .csr_trap_addr  (csr_trap_addr),
    .csr_trap_wdata (csr_trap_wdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        exc;
    logic        mret;
    logic [2:0]  irq;
    logic        ack;
    logic [31:0] mstatus;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        fr;
    logic        bsy;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
  } vec_t;

  vec_t tbl[13];

  int n_err;
  int n_checks;

  logic [11:0] wr_addr[8];
  logic [31:0] wr_data[8];
  int          n_wr;
  int          n_flush;
  int          rd_cyc;
  logic [31:0] rd_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller drives the request at posedge+1; cycle 0 is the acceptance cycle.
  task automatic run_seq(input int max_cyc, input int ack_delay, input bit keep_irq);
    n_wr = 0;
    n_flush = 0;
    rd_cyc = -1;
    rd_pc = '0;
    flush_ack = (ack_delay <= 1);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (flush_req) n_flush++;
      if (csr_trap_we && n_wr < 8) begin
        wr_addr[n_wr] = csr_trap_addr;
        wr_data[n_wr] = csr_trap_wdata;
        n_wr++;
      end
      if (redirect_valid) begin
        rd_cyc = c;
        rd_pc  = redirect_pc;
      end
      @(posedge clk);
      #1;
      if (c == 0) begin
        exc_valid  = 1'b0;
        mret_valid = 1'b0;
        if (!keep_irq) irq_pending = 3'b000;
      end
      flush_ack = (n_flush + 1 >= ack_delay);
      if (rd_cyc >= 0) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_err = 0;
    n_checks = 0;

    //              exc   mret  irq   ack   mstatus       mtvec         mepc          fr    bsy   we    addr    wdata         rv    rpc
    tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 12'h0,   32'h0,        1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b0, 12'h0,   32'h0,        1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 12'h341, 32'h80000104, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 12'h342, 32'h00000002, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 12'h343, 32'h00000013, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1, 12'h300, 32'h00001880, 1'b0, 32'h0};
    tbl[6]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 12'h0,   32'h0,        1'b1, 32'h80000000};
    tbl[7]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00000008, 32'h80000000, 32'h00000000, 1'b0, 1'b0, 1'b0, 12'h0,   32'h0,        1'b0, 32'h0};
    tbl[8]  = '{1'b0, 1'b1, 3'd0, 1'b1, 32'h00001880, 32'h80000000, 32'h80000104, 1'b0, 1'b0, 1'b0, 12'h0,   32'h0,        1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00001880, 32'h80000000, 32'h80000104, 1'b1, 1'b1, 1'b0, 12'h0,   32'h0,        1'b0, 32'h0};
    tbl[10] = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00001880, 32'h80000000, 32'h80000104, 1'b0, 1'b1, 1'b1, 12'h300, 32'h00001888, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00001880, 32'h80000000, 32'h80000104, 1'b0, 1'b1, 1'b0, 12'h0,   32'h0,        1'b1, 32'h80000104};
    tbl[12] = '{1'b0, 1'b0, 3'd0, 1'b1, 32'h00001880, 32'h80000000, 32'h80000104, 1'b0, 1'b0, 1'b0, 12'h0,   32'h0,        1'b0, 32'h0};

    reset_n     = 1'b0;
    exc_valid   = 1'b0;
    exc_cause   = 5'd0;
    exc_pc      = '0;
    exc_tval    = '0;
    mret_valid  = 1'b0;
    irq_pending = 3'b000;
    irq_pc      = '0;
    mie_q       = 3'b000;
    mstatus_q   = '0;
    mtvec_q     = '0;
    mepc_q      = '0;
    flush_ack   = 1'b0;

    #1;
    check("reset flush_req", {31'b0, flush_req}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset we", {31'b0, csr_trap_we}, 32'h0);
    check("reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
    check("reset redirect_pc", redirect_pc, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Illegal instruction trap followed by MRET, cycle by cycle
    exc_cause = 5'd2;
    exc_pc    = 32'h80000104;
    exc_tval  = 32'h00000013;
    for (int i = 0; i < 13; i++) begin
      exc_valid   = tbl[i].exc;
      mret_valid  = tbl[i].mret;
      irq_pending = tbl[i].irq;
      flush_ack   = tbl[i].ack;
      mstatus_q   = tbl[i].mstatus;
      mtvec_q     = tbl[i].mtvec;
      mepc_q      = tbl[i].mepc;
      @(negedge clk);
      check($sformatf("row%0d flush_req", i), {31'b0, flush_req}, {31'b0, tbl[i].fr});
      check($sformatf("row%0d busy", i), {31'b0, busy}, {31'b0, tbl[i].bsy});
      check($sformatf("row%0d we", i), {31'b0, csr_trap_we}, {31'b0, tbl[i].we});
      check($sformatf("row%0d addr", i), {20'b0, csr_trap_addr}, {20'b0, tbl[i].addr});
      check($sformatf("row%0d wdata", i), csr_trap_wdata, tbl[i].wdata);
      check($sformatf("row%0d redirect_valid", i), {31'b0, redirect_valid}, {31'b0, tbl[i].rv});
      check($sformatf("row%0d redirect_pc", i), redirect_pc, tbl[i].rpc);
      @(posedge clk);
      #1;
    end

    // Vectored timer interrupt
    mtvec_q     = 32'h80000101;
    mstatus_q   = 32'h00000008;
    mie_q       = 3'b010;
    irq_pending = 3'b010;
    irq_pc      = 32'h00000200;
    run_seq(30, 1, 1'b0);
    check("tmr n_wr", n_wr, 4);
    check("tmr mepc addr", {20'b0, wr_addr[0]}, 32'h341);
    check("tmr mepc", wr_data[0], 32'h00000200);
    check("tmr mcause addr", {20'b0, wr_addr[1]}, 32'h342);
    check("tmr mcause", wr_data[1], 32'h80000007);
    check("tmr mtval addr", {20'b0, wr_addr[2]}, 32'h343);
    check("tmr mtval", wr_data[2], 32'h0);
    check("tmr mstatus", wr_data[3], 32'h00001880);
    check("tmr redirect cycle", rd_cyc, 6);
    check("tmr redirect_pc", rd_pc, 32'h8000011C);

    // Globally masked interrupts
    begin
      logic seen_busy, seen_we, seen_rv;
      seen_busy = 1'b0;
      seen_we   = 1'b0;
      seen_rv   = 1'b0;
      mstatus_q   = 32'h00000000;
      mie_q       = 3'b111;
      irq_pending = 3'b111;
      repeat (20) begin
        @(negedge clk);
        seen_busy |= busy;
        seen_we   |= csr_trap_we;
        seen_rv   |= redirect_valid;
      end
      check("masked busy", {31'b0, seen_busy}, 32'h0);
      check("masked we", {31'b0, seen_we}, 32'h0);
      check("masked redirect", {31'b0, seen_rv}, 32'h0);
      @(posedge clk);
      #1;
    end

    // Exception, MRET and all interrupts at once: exception wins
    mstatus_q   = 32'h00000008;
    mtvec_q     = 32'h80000001;
    mie_q       = 3'b111;
    irq_pending = 3'b111;
    irq_pc      = 32'h00000300;
    exc_valid   = 1'b1;
    mret_valid  = 1'b1;
    exc_cause   = 5'd2;
    exc_pc      = 32'h00000100;
    exc_tval    = 32'h00000055;
    run_seq(30, 1, 1'b1);
    check("pri n_wr", n_wr, 4);
    check("pri mepc", wr_data[0], 32'h00000100);
    check("pri mcause", wr_data[1], 32'h00000002);
    check("pri mtval", wr_data[2], 32'h00000055);
    check("pri mstatus", wr_data[3], 32'h00001880);
    check("pri redirect_pc", rd_pc, 32'h80000000);

    // MIE now clear in the CSR file: pending MEI must wait
    mstatus_q = 32'h00001880;
    begin
      logic seen_busy;
      seen_busy = 1'b0;
      repeat (5) begin
        @(negedge clk);
        seen_busy |= busy;
      end
      check("wait mie busy", {31'b0, seen_busy}, 32'h0);
      @(posedge clk);
      #1;
    end

    mstatus_q   = 32'h00000088;
    irq_pending = 3'b111;
    run_seq(30, 1, 1'b0);
    check("mei mepc", wr_data[0], 32'h00000300);
    check("mei mcause", wr_data[1], 32'h8000000B);
    check("mei mtval", wr_data[2], 32'h0);
    check("mei mstatus", wr_data[3], 32'h00001880);
    check("mei redirect_pc", rd_pc, 32'h8000002C);

    irq_pending = 3'b011;
    run_seq(30, 1, 1'b0);
    check("msi mcause", wr_data[1], 32'h80000003);
    check("msi redirect_pc", rd_pc, 32'h8000000C);

    irq_pending = 3'b010;
    run_seq(30, 1, 1'b0);
    check("mti mcause", wr_data[1], 32'h80000007);
    check("mti redirect_pc", rd_pc, 32'h8000001C);

    // Delayed flush_ack, then reset pulsed during WR_MCAUSE
    begin
      bit found;
      found = 1'b0;
      n_flush = 0;
      n_wr = 0;
      mtvec_q   = 32'h00000000;
      mstatus_q = 32'h00000008;
      exc_cause = 5'd5;
      exc_pc    = 32'h00000040;
      exc_tval  = 32'h00000000;
      exc_valid = 1'b1;
      flush_ack = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (flush_req) n_flush++;
        if (csr_trap_we && csr_trap_addr == 12'h342) begin
          found = 1'b1;
          break;
        end
        if (csr_trap_we) n_wr++;
        @(posedge clk);
        #1;
        if (c == 0) exc_valid = 1'b0;
        flush_ack = (n_flush + 1 >= 5);
      end
      check("dly flush cycles", n_flush, 5);
      check("dly reached mcause", {31'b0, found}, 32'h1);
      check("dly writes before mcause", n_wr, 1);
      reset_n = 1'b0;
      #1;
      check("abort we", {31'b0, csr_trap_we}, 32'h0);
      check("abort addr", {20'b0, csr_trap_addr}, 32'h0);
      check("abort wdata", csr_trap_wdata, 32'h0);
      check("abort busy", {31'b0, busy}, 32'h0);
      check("abort flush_req", {31'b0, flush_req}, 32'h0);
      check("abort redirect_valid", {31'b0, redirect_valid}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      begin
        logic seen_act;
        seen_act = 1'b0;
        repeat (10) begin
          @(negedge clk);
          seen_act |= (csr_trap_we | busy | flush_req | redirect_valid);
        end
        check("post-reset activity", {31'b0, seen_act}, 32'h0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
